// File: rtl/daq_fifo_pkg.sv
// Widths and constants shared by the DAQ command path and the sample-path FIFO.
package daq_fifo_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;
    localparam logic [BYTE_W-1:0] PAD_BYTE = 8'h00;

    // First byte of a pair always lands in the upper half of the word.
    function automatic logic [WORD_W-1:0] pack_word(input logic [BYTE_W-1:0] hi_byte,
                                                    input logic [BYTE_W-1:0] lo_byte);
        return {hi_byte, lo_byte};
    endfunction

endpackage

// File: rtl/sync_word_ram.sv
// Simple dual-port word store: synchronous write, registered synchronous read.
module sync_word_ram
    import daq_fifo_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [ADDRESS_WIDTH-1:0] wr_addr,
    input  logic [WORD_W-1:0]        wr_data,
    input  logic                     rd_en,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr,
    output logic [WORD_W-1:0]        rd_data
);

    logic [WORD_W-1:0] mem [0:(1 << ADDRESS_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Only the output register is cleared; stale memory contents are unreachable after a clear.
    always_ff @(posedge clk) begin
        if (clear) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/daq_cmd_packer.sv
// Host-to-device command FIFO: packs byte pairs high-first into 16-bit words for the decoder.
module daq_cmd_packer
    import daq_fifo_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 6,
    parameter int FIFO_DEPTH    = 1 << ADDRESS_WIDTH
) (
    input  logic                   clk,
    input  logic                   clear,
    input  logic [BYTE_W-1:0]      data,
    input  logic                   wrreq,
    input  logic                   wrflush,
    output logic                   wrfull,
    output logic [WORD_W-1:0]      q,
    input  logic                   rdreq,
    output logic                   rdempty,
    output logic [ADDRESS_WIDTH:0] usedw,
    output logic                   pending,
    output logic                   overflow
);

    localparam logic [ADDRESS_WIDTH:0] FULL_COUNT = FIFO_DEPTH[ADDRESS_WIDTH:0];

    logic [BYTE_W-1:0]        hi_reg;
    logic [ADDRESS_WIDTH-1:0] wr_ptr;
    logic [ADDRESS_WIDTH-1:0] rd_ptr;
    logic                     accept;
    logic                     commit;
    logic                     load_hi;
    logic                     read_en;
    logic [WORD_W-1:0]        commit_word;

    assign wrfull  = (usedw == FULL_COUNT);
    assign rdempty = (usedw == '0);

    // A flush alongside a byte only matters when no high byte is held: the byte becomes a padded word.
    always_comb begin
        accept      = wrreq & ~wrfull;
        commit      = 1'b0;
        commit_word = '0;
        load_hi     = 1'b0;
        read_en     = rdreq & ~rdempty;
        if (accept) begin
            if (pending) begin
                commit      = 1'b1;
                commit_word = pack_word(hi_reg, data);
            end else if (wrflush) begin
                commit      = 1'b1;
                commit_word = pack_word(data, PAD_BYTE);
            end else begin
                load_hi = 1'b1;
            end
        end else if (wrflush && pending && !wrfull) begin
            commit      = 1'b1;
            commit_word = pack_word(hi_reg, PAD_BYTE);
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            hi_reg   <= '0;
            pending  <= 1'b0;
            overflow <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            usedw    <= '0;
        end else begin
            if (load_hi) begin
                hi_reg  <= data;
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
            if (wrreq && wrfull) begin
                overflow <= 1'b1;
            end
            if (commit) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (read_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (commit && !read_en) begin
                usedw <= usedw + 1'b1;
            end else if (read_en && !commit) begin
                usedw <= usedw - 1'b1;
            end
        end
    end

    sync_word_ram #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_ram (
        .clk     (clk),
        .clear   (clear),
        .wr_en   (commit),
        .wr_addr (wr_ptr),
        .wr_data (commit_word),
        .rd_en   (read_en),
        .rd_addr (rd_ptr),
        .rd_data (q)
    );

endmodule

// File: tb/tb_daq_cmd_packer.sv
// Directed bench for daq_cmd_packer with a queue model for the streaming phase.
module tb_daq_cmd_packer;
    import daq_fifo_pkg::*;

    localparam int AW    = 6;
    localparam int DEPTH = 1 << AW;

    logic              clk = 1'b0;
    logic              clear = 1'b0;
    logic [BYTE_W-1:0] data = '0;
    logic              wrreq = 1'b0;
    logic              wrflush = 1'b0;
    logic              rdreq = 1'b0;
    logic              wrfull;
    logic [WORD_W-1:0] q;
    logic              rdempty;
    logic [AW:0]       usedw;
    logic              pending;
    logic              overflow;

    int checks_total  = 0;
    int checks_passed = 0;

    logic [WORD_W-1:0] model_q[$];
    logic              m_pending;
    logic [BYTE_W-1:0] m_hi;
    logic [BYTE_W-1:0] next_byte;
    logic [WORD_W-1:0] exp_q;
    logic              r_bit;
    logic              do_read;
    logic              do_write;
    logic [7:0]        b;

    daq_cmd_packer #(.ADDRESS_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .clear    (clear),
        .data     (data),
        .wrreq    (wrreq),
        .wrflush  (wrflush),
        .wrfull   (wrfull),
        .q        (q),
        .rdreq    (rdreq),
        .rdempty  (rdempty),
        .usedw    (usedw),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Inputs change 1 ns after a rising edge, outputs are sampled at the same point.
    task automatic applyStimulus(input logic w, input logic f, input logic [7:0] d, input logic r);
        wrreq   = w;
        wrflush = f;
        data    = d;
        rdreq   = r;
        @(posedge clk);
        #1;
        wrreq   = 1'b0;
        wrflush = 1'b0;
        data    = '0;
        rdreq   = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks_total++;
        assert (observed === expected) checks_passed++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    task automatic doClear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_wrfull"}, 32'(wrfull), 32'd0);
        checkOutput({tag, "_rdempty"}, 32'(rdempty), 32'd1);
        checkOutput({tag, "_usedw"}, 32'(usedw), 32'd0);
        checkOutput({tag, "_pending"}, 32'(pending), 32'd0);
        checkOutput({tag, "_overflow"}, 32'(overflow), 32'd0);
        checkOutput({tag, "_q"}, 32'(q), 32'h0000);
    endtask

    initial begin
        $display("[TB] starting daq_cmd_packer bench");
        #1;
        doClear();
        checkReset("reset");

        // Basic pairing, high byte first
        applyStimulus(1, 0, 8'h12, 0);
        checkOutput("pair_pending", 32'(pending), 32'd1);
        checkOutput("pair_rdempty_hi", 32'(rdempty), 32'd1);
        applyStimulus(1, 0, 8'h34, 0);
        checkOutput("pair_rdempty_lo", 32'(rdempty), 32'd0);
        checkOutput("pair_usedw1", 32'(usedw), 32'd1);
        checkOutput("pair_pending_clr", 32'(pending), 32'd0);
        applyStimulus(1, 0, 8'h56, 0);
        applyStimulus(1, 0, 8'h78, 0);
        checkOutput("pair_usedw2", 32'(usedw), 32'd2);
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput("pair_q1", 32'(q), 32'h1234);
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput("pair_q2", 32'(q), 32'h5678);
        checkOutput("pair_rdempty_end", 32'(rdempty), 32'd1);

        // Flush of a held high byte
        applyStimulus(1, 0, 8'hAB, 0);
        applyStimulus(0, 1, 8'h00, 0);
        checkOutput("flush_pending", 32'(pending), 32'd0);
        checkOutput("flush_usedw", 32'(usedw), 32'd1);
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput("flush_q", 32'(q), 32'hAB00);

        // Fill to capacity, overflow, then drain
        for (int i = 0; i < 2 * DEPTH; i++) begin
            b = i[7:0];
            applyStimulus(1, 0, b, 0);
        end
        checkOutput("full_usedw", 32'(usedw), 32'(DEPTH));
        checkOutput("full_wrfull", 32'(wrfull), 32'd1);
        checkOutput("full_overflow_before", 32'(overflow), 32'd0);
        applyStimulus(1, 0, 8'hFF, 0);
        checkOutput("full_overflow", 32'(overflow), 32'd1);
        checkOutput("full_usedw_hold", 32'(usedw), 32'(DEPTH));
        checkOutput("full_pending_hold", 32'(pending), 32'd0);
        applyStimulus(0, 1, 8'h00, 1);
        checkOutput("full_read_q", 32'(q), 32'h0001);
        checkOutput("full_wrfull_drop", 32'(wrfull), 32'd0);
        checkOutput("full_usedw_63", 32'(usedw), 32'(DEPTH - 1));
        for (int k = 1; k < DEPTH; k++) begin
            applyStimulus(0, 0, 8'h00, 1);
            checkOutput("drain_q", 32'(q), 32'(((2 * k) << 8) | (2 * k + 1)));
        end
        checkOutput("drain_rdempty", 32'(rdempty), 32'd1);

        // Commit and read in the same cycle: refused when empty, both proceed otherwise
        applyStimulus(1, 0, 8'h11, 0);
        applyStimulus(1, 0, 8'h22, 1);
        checkOutput("empty_bound_q", 32'(q), 32'h7E7F);
        checkOutput("empty_bound_usedw", 32'(usedw), 32'd1);
        applyStimulus(1, 0, 8'h33, 0);
        applyStimulus(1, 0, 8'h44, 1);
        checkOutput("simul_q", 32'(q), 32'h1122);
        checkOutput("simul_usedw", 32'(usedw), 32'd1);
        checkOutput("simul_rdempty", 32'(rdempty), 32'd0);
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput("simul_q2", 32'(q), 32'h3344);

        // Reads while empty leave q and the pointers alone
        applyStimulus(0, 0, 8'h00, 1);
        applyStimulus(0, 0, 8'h00, 1);
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput("empty_rd_q", 32'(q), 32'h3344);
        checkOutput("empty_rd_usedw", 32'(usedw), 32'd0);
        applyStimulus(1, 0, 8'h55, 0);
        applyStimulus(1, 0, 8'h66, 0);
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput("empty_rd_next_q", 32'(q), 32'h5566);
        checkOutput("overflow_sticky", 32'(overflow), 32'd1);

        // Clear mid-pair with five words stored
        for (int i = 0; i < 11; i++) begin
            b = 8'hC0 + i[7:0];
            applyStimulus(1, 0, b, 0);
        end
        checkOutput("preclr_usedw", 32'(usedw), 32'd5);
        checkOutput("preclr_pending", 32'(pending), 32'd1);
        doClear();
        checkReset("midclr");
        applyStimulus(1, 0, 8'hA1, 0);
        applyStimulus(1, 0, 8'hB2, 0);
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput("postclr_q", 32'(q), 32'hA1B2);
        applyStimulus(0, 1, 8'h00, 0);
        checkOutput("idle_flush_usedw", 32'(usedw), 32'd0);

        // Streaming with random reads across several pointer wraps
        m_pending = 1'b0;
        m_hi      = '0;
        next_byte = 8'h00;
        for (int c = 0; c < 500; c++) begin
            r_bit    = ($urandom_range(0, 9) < 6);
            do_read  = r_bit && (model_q.size() != 0);
            do_write = (model_q.size() < DEPTH);
            exp_q    = '0;
            if (do_read) exp_q = model_q.pop_front();
            if (do_write) begin
                if (m_pending) begin
                    model_q.push_back({m_hi, next_byte});
                    m_pending = 1'b0;
                end else begin
                    m_hi      = next_byte;
                    m_pending = 1'b1;
                end
            end
            applyStimulus(1, 0, next_byte, r_bit);
            if (do_write) next_byte = next_byte + 8'd1;
            checkOutput("stream_usedw", 32'(usedw), 32'(model_q.size()));
            if (do_read) checkOutput("stream_q", 32'(q), 32'(exp_q));
        end

        // Byte and flush together with nothing held
        doClear();
        checkReset("clr2");
        applyStimulus(1, 1, 8'h9C, 0);
        checkOutput("wf_pending", 32'(pending), 32'd0);
        checkOutput("wf_usedw", 32'(usedw), 32'd1);
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput("wf_q", 32'(q), 32'h9C00);
        checkOutput("wf_rdempty", 32'(rdempty), 32'd1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/daq_cmd_packer.md
# daq_cmd_packer

Host-to-device byte-to-word FIFO for the DAQ command and configuration path, opposite in direction to the sample stream. Accepts 8-bit bytes from the host-side interface, packs byte pairs high-byte-first into 16-bit words, and buffers them for the FPGA-side command decoder. Single clock domain: the host interface and the decoder share `clk`.

## Interface
Parameters:
- `ADDRESS_WIDTH`, 6: word-address width.
- `FIFO_DEPTH`, `1 << ADDRESS_WIDTH`: capacity in 16-bit words.

Ports:
- `clk`  in  1: single clock; all logic on posedge.
- `clear`  in  1: reset, synchronous and active-high.
- `data`  in  8: write byte.
- `wrreq`  in  1: byte write request.
- `wrflush`  in  1: commit a pending high byte as a padded word.
- `wrfull`  out  1: word store full; bytes refused.
- `q`  out  16: read word, registered.
- `rdreq`  in  1: word read request.
- `rdempty`  out  1: no committed words.
- `usedw`  out  ADDRESS_WIDTH+1: committed word count, 0..FIFO_DEPTH.
- `pending`  out  1: high byte held, awaiting low byte.
- `overflow`  out  1: sticky; a byte was dropped.

## Operation
- Reset values after a `clear` edge: `wrfull`=0, `rdempty`=1, `usedw`=0, `pending`=0, `overflow`=0, `q`=16'h0000. Read/write pointers are 0 and any held byte is discarded. `clear` overrides every other input in that cycle.
- Byte accepted when `wrreq & !wrfull`.
  - If `pending`=0, the byte goes to `hi_reg` and `pending` is set.
  - If `pending`=1, the word {`hi_reg`, `data`} is written at the write pointer, the pointer increments, and `pending` clears.
- Byte order: first byte of each pair is bits [15:8], second is [7:0].
- `wrreq & wrfull`: byte dropped, `overflow` set (sticky until `clear`), `pending` and `hi_reg` unchanged.
- `wrflush` with `pending`=1 and `!wrfull`: commits {`hi_reg`, 8'h00} and clears `pending`. `wrflush` with `pending`=0 does nothing.
- `wrflush & wrreq` in the same cycle:
  - If `pending`=1, the byte completes the word and the flush is a no-op.
  - If `pending`=0, the word {`data`, 8'h00} is committed directly.
- `wrflush` while `wrfull`: ignored, `pending` held.
- Word read when `rdreq & !rdempty`: `q` <= mem[read pointer] and the read pointer increments. `rdreq & rdempty`: ignored, `q` holds, no error flag.
- `usedw` update per cycle: +1 on commit only, −1 on read only, unchanged when both or neither occur.
- `wrfull` = (`usedw` == FIFO_DEPTH). `rdempty` = (`usedw` == 0). Both are derived from the registered count.
- Pointers are binary and wrap modulo FIFO_DEPTH. Wrap is transparent.

## Timing
- Write latency: a word committed at edge N gives `usedw`+1 and `rdempty`=0 in cycle N+1. A read may be issued in cycle N+1.
- Read latency: `rdreq` sampled at edge N makes `q` valid from N until edge N+1 of the next read.
- Full boundary: a commit and a read in the same cycle while `usedw`=FIFO_DEPTH cannot occur, because the byte is refused by `wrfull`. The read proceeds and `wrfull` drops the next cycle.
- Empty boundary: a commit and a read in the same cycle while `usedw`=0: the read is refused by `rdempty` and the word becomes readable next cycle.
- Simultaneous commit and read at 0 < `usedw` < FIFO_DEPTH: both proceed, `usedw` is unchanged, and the flags are unchanged.
- `clear` mid-pair or mid-stream drops all data in the cycle after the edge.

## Structure
- Shared package `daq_fifo_pkg`: `BYTE_W`=8, `WORD_W`=16, `PAD_BYTE`=8'h00. This package is shared with the sample-path FIFO.
- Sub-module `sync_word_ram`: 1 write port and 1 read port, both synchronous, FIFO_DEPTH×WORD_W, with a registered read. It is instantiated once.
- Top level holds the packer (`hi_reg`, `pending`), pointers, count, and flags.

## Test plan
- Reset, then write bytes 0x12, 0x34, 0x56, 0x78 and read twice -> `q`=0x1234 then 0x5678. `rdempty` is 0 one cycle after 0x34 is accepted.
- Write 0xAB then pulse `wrflush` -> one word 0xAB00, `pending` returns to 0, `usedw`=1.
- Fill 64 words (128 bytes), then write 0xFF -> `wrfull`=1, `overflow`=1, `usedw`=64. One read gives `wrfull`=0 the next cycle.
- Continuous 2-bytes-per-read streaming across 3 pointer wraps with random `rdreq` -> data order preserved and `usedw` matches the model each cycle.
- `rdreq` held while empty -> `q` holds its last value and the pointers do not move. Assert `clear` with `pending`=1 and `usedw`=5 -> all outputs return to their reset values next cycle.
- Same-cycle `wrreq` (0x9C) and `wrflush` with `pending`=0 -> one word 0x9C00 and `pending` stays 0.
